mem_access_unit: RTL and testbench

Sits between the pipeline MEM stage and the memory/peripheral subsystem bus (read, write, address, writedata, readdata).
- Converts MEM-stage load/store requests of byte, halfword or word size into word-wide bus cycles.
- Extracts and sign- or zero-extends load data.
- Performs a 2-cycle read-modify-write for sub-word stores, stalling the pipeline for 1 cycle.
- Flags misaligned accesses.

---
 rtl/mem_access_pkg.sv | 41 ++++
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size codes, FSM states and byte-lane helpers
// shared by mem_access_unit and mem_lane_align.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_e;

    // Physical byte lane that holds logical byte 'off' of a word.
    function automatic logic [1:0] phys_byte(
        input logic [1:0] off,
        input logic       le
    );
        return le ? off : ~off;
    endfunction

    // Byte enables covering the lane(s) touched by an access.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] off,
        input logic [1:0] size,
        input logic       le
    );
        logic [3:0] m;
        logic       hp;
        hp = le ? off[1] : ~off[1];
        if (size == SZ_BYTE) begin
            m = 4'b0001 << phys_byte(off, le);
        end else if (size == SZ_HALF) begin
            m = hp ? 4'b1100 : 4'b0011;
        end else begin
            m = 4'b1111;
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: load lane extraction/extension and
// sub-word store merge, purely combinational.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [15:0] st_new,
    input  logic [3:0]  st_be,
    input  logic [1:0]  st_size,
    output logic [31:0] st_word
);

    localparam logic LE = (LITTLE_ENDIAN != 0);

    logic [1:0]  ld_lane;
    logic        ld_hsel;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] st_rep;

    // Pick the addressed lane and extend it to a full word.
    always_comb begin
        ld_lane = phys_byte(ld_off, LE);
        ld_hsel = LE ? ld_off[1] : ~ld_off[1];
        unique case (ld_lane)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_hsel ? ld_word[31:16] : ld_word[15:0];
        unique case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    // Replicate new data over all lanes, keep only the enabled bytes.
    always_comb begin
        st_word = st_old;
        if (st_size == SZ_HALF) begin
            st_rep = {2{st_new}};
        end else begin
            st_rep = {4{st_new[7:0]}};
        end
        for (int i = 0; i < 4; i++) begin
            if (st_be[i]) begin
                st_word[8*i +: 8] = st_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage to word bus adapter with sub-word RMW.
// Define MEM_MISALIGN_TRAP_EN to flag and drop misaligned accesses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int LITTLE_ENDIAN = 1,
    parameter int IRQ_HOLD      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        addr_err,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam logic LE = (LITTLE_ENDIAN != 0);

    state_e      state_q, state_d;
    logic [31:0] cap_q, cap_d;
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  size_q, size_d;
    logic [15:0] wdata_q, wdata_d;
    logic [29:0] addr_q, addr_d;

    logic        act;
    logic        is_word;
    logic        mis;
    logic [1:0]  off_eff;
    logic [31:0] ld_ext;
    logic [31:0] st_word;

    // IRQ_HOLD is reserved; any nonzero value keeps the unit quiet.
    assign act     = reset && (IRQ_HOLD == 0);
    assign is_word = req_size[1];

`ifdef MEM_MISALIGN_TRAP_EN
    assign off_eff = req_addr[1:0];
    assign mis     = is_word ? (req_addr[1:0] != 2'b00)
                             : (req_size[0] & req_addr[0]);
`else
    assign off_eff = is_word ? 2'b00
                             : {req_addr[1], req_addr[0] & ~req_size[0]};
    assign mis     = 1'b0;
`endif

    mem_lane_align #(
        .LITTLE_ENDIAN (LITTLE_ENDIAN)
    ) u_align (
        .ld_word   (bus_rdata),
        .ld_off    (off_eff),
        .ld_size   (req_size),
        .ld_signed (req_signed),
        .ld_data   (ld_ext),
        .st_old    (cap_q),
        .st_new    (wdata_q),
        .st_be     (mask_q),
        .st_size   (size_q),
        .st_word   (st_word)
    );

    // Next state, RMW capture and the bus/pipeline strobes.
    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        mask_d    = mask_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        stall     = 1'b0;
        addr_err  = 1'b0;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        bus_wdata = '0;
        ld_data   = '0;
        bus_addr  = {req_addr[31:2], 2'b00};
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (mis) begin
                        addr_err = 1'b1;
                    end else if (!req_write) begin
                        bus_read = 1'b1;
                        ld_data  = ld_ext;
                    end else if (is_word) begin
                        bus_write = 1'b1;
                        bus_wdata = req_wdata;
                    end else begin
                        bus_read = 1'b1;
                        stall    = 1'b1;
                        cap_d    = bus_rdata;
                        mask_d   = lane_mask(off_eff, req_size, LE);
                        size_d   = req_size;
                        wdata_d  = req_wdata[15:0];
                        addr_d   = req_addr[31:2];
                        state_d  = ST_RMW_WR;
                    end
                end
            end
            ST_RMW_WR: begin
                bus_write = 1'b1;
                bus_addr  = {addr_q, 2'b00};
                bus_wdata = st_word;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!act) begin
            stall     = 1'b0;
            addr_err  = 1'b0;
            bus_read  = 1'b0;
            bus_write = 1'b0;
            bus_wdata = '0;
            ld_data   = '0;
            state_d   = ST_IDLE;
        end
    end

    // FSM state and RMW capture; reset drops any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cap_q   <= '0;
            mask_q  <= '0;
            size_q  <= SZ_BYTE;
            wdata_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            mask_q  <= mask_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random checks of mem_access_unit
// against a little-endian byte-lane memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        addr_err;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    logic [31:0] bus_mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    int total = 0;
    int bad   = 0;

    logic        v, w, sg, trap;
    logic [1:0]  sz;
    logic [31:0] a, d, x, m, e;
    int          nb, off;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .ld_data    (ld_data),
        .addr_err   (addr_err),
        .bus_read   (bus_read),
        .bus_write  (bus_write),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata)
    );

    assign bus_rdata = bus_mem[bus_addr[9:2]];

    always @(posedge clk) begin
        if (bus_write) begin
            bus_mem[bus_addr[9:2]] <= bus_wdata;
        end else if (pre_en) begin
            bus_mem[pre_idx] <= pre_val;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic rd, input logic wr,
                           input logic st, input logic er);
        chk({tag, ".read"},  {31'd0, bus_read},  {31'd0, rd});
        chk({tag, ".write"}, {31'd0, bus_write}, {31'd0, wr});
        chk({tag, ".stall"}, {31'd0, stall},     {31'd0, st});
        chk({tag, ".err"},   {31'd0, addr_err},  {31'd0, er});
        chk({tag, ".excl"},  {31'd0, bus_read & bus_write}, 32'd0);
    endtask

    task automatic drive(input logic iv, input logic iw, input logic [1:0] isz,
                         input logic isg, input logic [31:0] ia,
                         input logic [31:0] id);
        @(negedge clk);
        req_valid  = iv;
        req_write  = iw;
        req_size   = isz;
        req_signed = isg;
        req_addr   = ia;
        req_wdata  = id;
        #2;
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        @(negedge clk);
        req_valid = 1'b0;
        pre_en    = 1'b1;
        pre_idx   = 8'(idx);
        pre_val   = val;
        ref_mem[idx] = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_signed = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        pre_en = 1'b0;
        pre_idx = '0;
        pre_val = '0;

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pre_en  = 1'b1;
            pre_idx = 8'(i);
            pre_val = $urandom;
            ref_mem[i] = pre_val;
        end
        @(negedge clk);
        pre_en = 1'b0;

        // reset holds every output low even with a request present
        drive(1, 0, 2'b10, 0, 32'h100, 0);
        chk_bus("rst_ld", 0, 0, 0, 0);
        chk("rst_ld.ld_data", ld_data, 32'h0);
        drive(1, 1, 2'b00, 0, 32'h202, 32'hAB);
        chk_bus("rst_st", 0, 0, 0, 0);
        chk("rst_st.wdata", bus_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;

        // word and byte loads
        set_word(32'h100 >> 2, 32'h8899AABB);
        drive(1, 0, 2'b10, 0, 32'h100, 0);
        chk_bus("ldw", 1, 0, 0, 0);
        chk("ldw.data", ld_data, 32'h8899AABB);
        chk("ldw.addr", bus_addr, 32'h100);
        drive(1, 0, 2'b00, 1, 32'h103, 0);
        chk("ldbs.data", ld_data, 32'hFFFFFF88);
        drive(1, 0, 2'b00, 0, 32'h103, 0);
        chk("ldbu.data", ld_data, 32'h00000088);
        drive(1, 0, 2'b01, 0, 32'h101, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk_bus("ldh_mis", 0, 0, 0, 1);
        chk("ldh_mis.data", ld_data, 32'h0);
`else
        chk_bus("ldh_mis", 1, 0, 0, 0);
        chk("ldh_mis.data", ld_data, 32'h0000AABB);
`endif

        // byte store read-modify-write
        set_word(32'h200 >> 2, 32'h11223344);
        drive(1, 1, 2'b00, 0, 32'h202, 32'hAB);
        chk_bus("stb1", 1, 0, 1, 0);
        drive(1, 1, 2'b00, 0, 32'h202, 32'hAB);
        chk_bus("stb2", 0, 1, 0, 0);
        chk("stb2.wdata", bus_wdata, 32'h11AB3344);
        chk("stb2.addr", bus_addr, 32'h200);
        ref_mem[32'h200 >> 2] = 32'h11AB3344;
        drive(1, 0, 2'b10, 0, 32'h200, 0);
        chk("stb.readback", ld_data, 32'h11AB3344);

        // halfword store
        set_word(32'h200 >> 2, 32'h11223344);
        drive(1, 1, 2'b01, 0, 32'h200, 32'h0000BEEF);
        chk_bus("sth1", 1, 0, 1, 0);
        drive(1, 1, 2'b01, 0, 32'h200, 32'h0000BEEF);
        chk_bus("sth2", 0, 1, 0, 0);
        chk("sth2.wdata", bus_wdata, 32'h1122BEEF);
        ref_mem[32'h200 >> 2] = 32'h1122BEEF;

        // misaligned word store
        drive(1, 1, 2'b10, 0, 32'h302, 32'hCAFEF00D);
`ifdef MEM_MISALIGN_TRAP_EN
        chk_bus("stw_mis", 0, 0, 0, 1);
`else
        chk_bus("stw_mis", 0, 1, 0, 0);
        chk("stw_mis.addr", bus_addr, 32'h300);
        chk("stw_mis.wdata", bus_wdata, 32'hCAFEF00D);
        ref_mem[32'h300 >> 2] = 32'hCAFEF00D;
`endif

        // top-of-memory word address
        set_word(255, 32'h5A5A0001);
        drive(1, 0, 2'b10, 0, 32'hFFFFFFFC, 0);
        chk("wrap.addr", bus_addr, 32'hFFFFFFFC);
        chk("wrap.data", ld_data, 32'h5A5A0001);

        // no request
        drive(0, 1, 2'b00, 0, 32'h12345677, 32'hFF);
        chk_bus("idle", 0, 0, 0, 0);
        chk("idle.addr", bus_addr, 32'h12345674);
        chk("idle.wdata", bus_wdata, 32'h0);

        // reset during the write half of an RMW
        set_word(32'h40 >> 2, 32'hA1B2C3D4);
        drive(1, 1, 2'b00, 0, 32'h41, 32'h77);
        chk_bus("rmid1", 1, 0, 1, 0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk_bus("rmid2", 0, 0, 0, 0);
        chk("rmid2.wdata", bus_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        #2;
        chk_bus("rmid_rel", 0, 0, 0, 0);
        chk("rmid_rel.ld", ld_data, 32'h0);
        chk("rmid_rel.wdata", bus_wdata, 32'h0);
        drive(1, 0, 2'b10, 0, 32'h40, 0);
        chk("rmid.nowrite", ld_data, 32'hA1B2C3D4);
        drive(1, 1, 2'b00, 0, 32'h41, 32'h77);
        chk_bus("rmid_again1", 1, 0, 1, 0);
        drive(1, 1, 2'b00, 0, 32'h41, 32'h77);
        chk_bus("rmid_again2", 0, 1, 0, 0);
        chk("rmid_again2.wdata", bus_wdata, 32'hA1B277D4);
        ref_mem[32'h40 >> 2] = 32'hA1B277D4;

        // random traffic against the byte-lane model
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 9) != 0);
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            d  = $urandom;
            nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            off = int'(a[1:0]);
            trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            trap = ((off % nb) != 0);
`else
            off = off - (off % nb);
`endif
            drive(v, w, sz, sg, a, d);
            if (!v) begin
                chk_bus("r_idle", 0, 0, 0, 0);
                chk("r_idle.addr", bus_addr, a & ~32'd3);
            end else if (trap) begin
                chk_bus("r_mis", 0, 0, 0, 1);
                chk("r_mis.ld", ld_data, 32'h0);
            end else if (!w) begin
                x = ref_mem[a[9:2]] >> (8 * off);
                if (nb == 1) begin
                    x = x & 32'hFF;
                    if (sg && x[7]) x = x | 32'hFFFFFF00;
                end else if (nb == 2) begin
                    x = x & 32'hFFFF;
                    if (sg && x[15]) x = x | 32'hFFFF0000;
                end
                chk_bus("r_ld", 1, 0, 0, 0);
                chk("r_ld.addr", bus_addr, a & ~32'd3);
                chk("r_ld.data", ld_data, x);
            end else if (nb == 4) begin
                chk_bus("r_stw", 0, 1, 0, 0);
                chk("r_stw.addr", bus_addr, a & ~32'd3);
                chk("r_stw.wdata", bus_wdata, d);
                ref_mem[a[9:2]] = d;
            end else begin
                chk_bus("r_rmw1", 1, 0, 1, 0);
                m = (nb == 1) ? 32'hFF : 32'hFFFF;
                m = m << (8 * off);
                e = (ref_mem[a[9:2]] & ~m) | ((d << (8 * off)) & m);
                drive(v, w, sz, sg, a, d);
                chk_bus("r_rmw2", 0, 1, 0, 0);
                chk("r_rmw2.addr", bus_addr, a & ~32'd3);
                chk("r_rmw2.wdata", bus_wdata, e);
                ref_mem[a[9:2]] = e;
            end
        end

        @(negedge clk);
        req_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
